// File: rtl/lsu_port_arbiter.sv
// Shares one req/gnt/rvalid LSU data port among N_REQ requesters, round-robin issue with in-order response routing.
// Optional build macro LSU_ARB_PRIO0_EN: requester 0 gets strict priority, the rest share round-robin.
module lsu_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4,
  parameter int IDX_W     = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 s_req_i,
  input  logic [N_REQ*32-1:0]              s_addr_i,
  input  logic [N_REQ-1:0]                 s_we_i,
  input  logic [N_REQ*4-1:0]               s_be_i,
  input  logic [N_REQ*32-1:0]              s_wdata_i,
  output logic [N_REQ-1:0]                 s_gnt_o,
  output logic [N_REQ-1:0]                 s_rvalid_o,
  output logic [N_REQ-1:0]                 s_err_o,
  output logic [31:0]                      s_rdata_o,
  output logic                             m_req_o,
  output logic [31:0]                      m_addr_o,
  output logic                             m_we_o,
  output logic [3:0]                       m_be_o,
  output logic [31:0]                      m_wdata_o,
  input  logic                             m_gnt_i,
  input  logic                             m_rvalid_i,
  input  logic                             m_err_i,
  input  logic [31:0]                      m_rdata_i,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding_o,
  output logic                             proto_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
`ifdef LSU_ARB_PRIO0_EN
  localparam logic [IDX_W-1:0] WRAP_IDX = IDX_W'(32'd1);
`else
  localparam logic [IDX_W-1:0] WRAP_IDX = '0;
`endif

  logic [IDX_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             proto_err_q, proto_err_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTST];

  logic [31:0]      addr_s  [N_REQ];
  logic [31:0]      wdata_s [N_REQ];
  logic [3:0]       be_s    [N_REQ];
  logic [IDX_W:0]   cand_sum_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             cand_ok_s;
  logic [IDX_W-1:0] scan_win_s;
  logic             scan_hit_s;
  logic [IDX_W-1:0] win_s;
  logic [IDX_W-1:0] head_s;
  logic             m_req_s;
  logic             hs_s;
  logic             rsp_s;

  // Unpack the flat per-requester buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_s[i]  = s_addr_i[i*32 +: 32];
      wdata_s[i] = s_wdata_i[i*32 +: 32];
      be_s[i]    = s_be_i[i*4 +: 4];
    end
  end

  // Round-robin scan: first requester at or after rr_q, wrapping at N_REQ.
  always_comb begin
    scan_win_s = rr_q;
    scan_hit_s = 1'b0;
    cand_sum_s = '0;
    cand_idx_s = '0;
    cand_ok_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum_s = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (cand_sum_s >= N_REQ_W) begin
        cand_sum_s = cand_sum_s - N_REQ_W;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_idx_s = cand_sum_s[IDX_W-1:0];
`ifdef LSU_ARB_PRIO0_EN
      cand_ok_s = s_req_i[cand_idx_s] && (cand_idx_s != '0);
`else
      cand_ok_s = s_req_i[cand_idx_s];
`endif
      if (!scan_hit_s && cand_ok_s) begin
        scan_win_s = cand_idx_s;
        scan_hit_s = 1'b1;
      end else begin
        scan_hit_s = scan_hit_s;
      end
    end
  end

  // A locked requester keeps the port until its handshake so the memory sees stable fields.
  always_comb begin
    win_s = scan_win_s;
    if (lock_q) begin
      win_s = lock_idx_q;
`ifdef LSU_ARB_PRIO0_EN
    end else if (s_req_i[0]) begin
      win_s = '0;
`endif
    end else begin
      win_s = scan_win_s;
    end
  end

  assign head_s  = fifo_q[rd_ptr_q];
  // A pop in the same cycle deliberately does not relieve a full FIFO.
  assign m_req_s = s_req_i[win_s] & (count_q < FULL_CNT);
  assign hs_s    = m_req_s & m_gnt_i;
  assign rsp_s   = m_rvalid_i & (count_q != '0);

  // Zero-latency request mux, grant steering and response routing.
  always_comb begin
    m_req_o    = m_req_s;
    m_addr_o   = '0;
    m_we_o     = 1'b0;
    m_be_o     = '0;
    m_wdata_o  = '0;
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    s_err_o    = '0;
    s_rdata_o  = '0;
    if (m_req_s) begin
      m_addr_o  = addr_s[win_s];
      m_we_o    = s_we_i[win_s];
      m_be_o    = be_s[win_s];
      m_wdata_o = wdata_s[win_s];
    end else begin
      m_addr_o  = '0;
    end
    if (hs_s) begin
      s_gnt_o[win_s] = 1'b1;
    end else begin
      s_gnt_o = '0;
    end
    if (rsp_s) begin
      s_rvalid_o[head_s] = 1'b1;
      s_err_o[head_s]    = m_err_i;
      s_rdata_o          = m_rdata_i;
    end else begin
      s_rdata_o = '0;
    end
  end

  // Next-state for lock, round-robin pointer, FIFO pointers, count and protocol flag.
  always_comb begin
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    rr_d        = rr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;
    if (hs_s) begin
      lock_d   = 1'b0;
      rr_d     = (win_s == LAST_IDX) ? WRAP_IDX : (win_s + 1'b1);
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (m_req_s) begin
      lock_d     = 1'b1;
      lock_idx_d = win_s;
    end else begin
      lock_d = lock_q;
    end
    if (rsp_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({hs_s, rsp_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (m_rvalid_i && (count_q == '0)) begin
      proto_err_d = 1'b1;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // State registers and the routing FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      proto_err_q <= proto_err_d;
      if (hs_s) begin
        fifo_q[wr_ptr_q] <= win_s;
      end
    end
  end

  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter (N_REQ=2, MAX_OUTST=4) with a response-routing scoreboard.
module tb_lsu_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_req_i, s_we_i;
  logic [63:0] s_addr_i, s_wdata_i;
  logic [7:0]  s_be_i;
  logic [1:0]  s_gnt_o, s_rvalid_o, s_err_o;
  logic [31:0] s_rdata_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;
  logic        m_gnt_i, m_rvalid_i, m_err_i;
  logic [31:0] m_rdata_i;
  logic [2:0]  outstanding_o;
  logic        proto_err_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned sb[$];
  int exp_w;

  always #5 clk = ~clk;

  lsu_port_arbiter #(.N_REQ(2), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_we_i(s_we_i), .s_be_i(s_be_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o),
    .s_err_o(s_err_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_err_i(m_err_i), .m_rdata_i(m_rdata_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the expected responder and checks routing, error and data.
  task automatic rsp_chk(input string tag, input logic err);
    int unsigned idx;
    logic [1:0] oh;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() != 0) begin
      idx = sb.pop_front();
      oh  = 2'b01 << idx;
      chk({tag, "_rvalid"}, {30'd0, s_rvalid_o}, {30'd0, oh});
      chk({tag, "_err"}, {30'd0, s_err_o}, err ? {30'd0, oh} : 32'd0);
      chk({tag, "_rdata"}, s_rdata_o, m_rdata_i);
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_req_i = 2'b00; s_we_i = 2'b00; s_be_i = 8'h00;
    s_addr_i = 64'h0; s_wdata_i = 64'h0;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_err_i = 1'b0; m_rdata_i = 32'h0;
    #3;
    chk("rst_outst", {29'd0, outstanding_o}, 32'd0);
    chk("rst_proto", {31'd0, proto_err_o}, 32'd0);
    chk("rst_mreq", {31'd0, m_req_o}, 32'd0);
    chk("rst_gnt", {30'd0, s_gnt_o}, 32'd0);
    chk("rst_rvalid", {30'd0, s_rvalid_o}, 32'd0);
    #10 rst_n = 1'b1;
    nxt();

    // single request and response
    s_req_i = 2'b01; s_addr_i = {32'h0000_0999, 32'h0000_0100};
    s_we_i = 2'b01; s_be_i = 8'h0F; s_wdata_i = {32'h0, 32'hDEAD_BEEF}; m_gnt_i = 1'b1;
    settle();
    chk("single_mreq", {31'd0, m_req_o}, 32'd1);
    chk("single_addr", m_addr_o, 32'h100);
    chk("single_we", {31'd0, m_we_o}, 32'd1);
    chk("single_be", {28'd0, m_be_o}, 32'hF);
    chk("single_wdata", m_wdata_o, 32'hDEAD_BEEF);
    chk("single_gnt", {30'd0, s_gnt_o}, 32'd1);
    sb.push_back(0);
    nxt();
    s_req_i = 2'b00; s_we_i = 2'b00; s_be_i = 8'h00; m_gnt_i = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE;
    settle();
    chk("single_outst1", {29'd0, outstanding_o}, 32'd1);
    chk("idle_addr_zero", m_addr_o, 32'd0);
    rsp_chk("single_rsp", 1'b0);
    nxt();
    m_rvalid_i = 1'b0;
    settle();
    chk("single_outst0", {29'd0, outstanding_o}, 32'd0);

    // fairness, both requesting; rr now points at requester 1
    nxt();
    s_req_i = 2'b11; s_addr_i = {32'h0000_0300, 32'h0000_0200}; m_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef LSU_ARB_PRIO0_EN
      exp_w = 0;
`else
      exp_w = (k % 2 == 0) ? 1 : 0;
`endif
      settle();
      chk("fair_gnt", {30'd0, s_gnt_o}, 32'd1 << exp_w);
      chk("fair_addr", m_addr_o, (exp_w == 1) ? 32'h300 : 32'h200);
      sb.push_back(exp_w);
      nxt();
    end

    // FIFO full: requests held, nothing issues
    settle();
    chk("full_mreq", {31'd0, m_req_o}, 32'd0);
    chk("full_gnt", {30'd0, s_gnt_o}, 32'd0);
    chk("full_outst", {29'd0, outstanding_o}, 32'd4);
    nxt();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h1111;
    settle();
    chk("full_pop_mreq", {31'd0, m_req_o}, 32'd0);
    rsp_chk("full_rsp", 1'b0);
    nxt();
    m_rvalid_i = 1'b0;
    settle();
    chk("after_pop_outst", {29'd0, outstanding_o}, 32'd3);
    chk("after_pop_mreq", {31'd0, m_req_o}, 32'd1);
`ifdef LSU_ARB_PRIO0_EN
    exp_w = 0;
`else
    exp_w = 1;
`endif
    chk("after_pop_gnt", {30'd0, s_gnt_o}, 32'd1 << exp_w);
    sb.push_back(exp_w);
    nxt();
    s_req_i = 2'b00; m_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'h2000 + k; m_err_i = k[0];
      settle();
      rsp_chk("drain_rsp", k[0]);
      nxt();
    end
    m_rvalid_i = 1'b0; m_err_i = 1'b0;
    settle();
    chk("drain_outst", {29'd0, outstanding_o}, 32'd0);

    // ordering and error routing
    nxt();
    s_req_i = 2'b10; m_gnt_i = 1'b1;
    settle();
    chk("ord_gnt1", {30'd0, s_gnt_o}, 32'd2);
    sb.push_back(1);
    nxt();
    s_req_i = 2'b01;
    settle();
    chk("ord_gnt0", {30'd0, s_gnt_o}, 32'd1);
    sb.push_back(0);
    nxt();
    s_req_i = 2'b00; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_err_i = 1'b1; m_rdata_i = 32'hA;
    settle();
    rsp_chk("ord_rsp_r1", 1'b1);
    nxt();
    m_err_i = 1'b0; m_rdata_i = 32'hB;
    settle();
    rsp_chk("ord_rsp_r0", 1'b0);
    nxt();
    m_rvalid_i = 1'b0;

    // lock: requester 0 stalled, then requester 1 joins while rr favours it
    s_req_i = 2'b01; m_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("lock_addr", m_addr_o, 32'h200);
      chk("lock_gnt", {30'd0, s_gnt_o}, 32'd0);
      nxt();
    end
    s_req_i = 2'b11;
    settle();
    chk("lock_both_addr", m_addr_o, 32'h200);
    nxt();
    m_gnt_i = 1'b1;
    settle();
    chk("lock_release_gnt", {30'd0, s_gnt_o}, 32'd1);
    sb.push_back(0);
    nxt();
`ifdef LSU_ARB_PRIO0_EN
    exp_w = 0;
`else
    exp_w = 1;
`endif
    settle();
    chk("lock_next_gnt", {30'd0, s_gnt_o}, 32'd1 << exp_w);
    sb.push_back(exp_w);
    nxt();
    s_req_i = 2'b00; m_gnt_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rvalid_i = 1'b1; m_rdata_i = 32'h3000 + k;
      settle();
      rsp_chk("lock_rsp", 1'b0);
      nxt();
    end
    m_rvalid_i = 1'b0;

    // stray response: dropped, sticky protocol error
    settle();
    chk("proto_pre_outst", {29'd0, outstanding_o}, 32'd0);
    nxt();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h5555;
    settle();
    chk("proto_no_rvalid", {30'd0, s_rvalid_o}, 32'd0);
    chk("proto_not_yet", {31'd0, proto_err_o}, 32'd0);
    nxt();
    m_rvalid_i = 1'b0;
    settle();
    chk("proto_set", {31'd0, proto_err_o}, 32'd1);
    nxt(); nxt();
    settle();
    chk("proto_sticky", {31'd0, proto_err_o}, 32'd1);

    // reset with two outstanding
    nxt();
    s_req_i = 2'b01; m_gnt_i = 1'b1;
    nxt(); nxt();
    s_req_i = 2'b00; m_gnt_i = 1'b0;
    settle();
    chk("pre_rst_outst", {29'd0, outstanding_o}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outst", {29'd0, outstanding_o}, 32'd0);
    chk("mid_rst_proto", {31'd0, proto_err_o}, 32'd0);
    sb.delete();
    nxt();
    rst_n = 1'b1;
    nxt();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h7777;
    settle();
    chk("post_rst_no_rvalid", {30'd0, s_rvalid_o}, 32'd0);
    nxt();
    m_rvalid_i = 1'b0;
    settle();
    chk("post_rst_proto", {31'd0, proto_err_o}, 32'd1);
    chk("post_rst_outst", {29'd0, outstanding_o}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
